// File: rtl/fp16_mul_axis.sv
// AXI4-Stream binary16 multiplier: joined A/B operand handshake, operand capture
// register followed by unpack/multiply, normalise/round and special-select stages.
module fp16_mul_axis #(
  parameter int unsigned TAG_W = 4
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             s_axis_a_tvalid,
  output logic             s_axis_a_tready,
  input  logic [15:0]      s_axis_a_tdata,
  input  logic [TAG_W-1:0] s_axis_a_tuser,
  input  logic             s_axis_b_tvalid,
  output logic             s_axis_b_tready,
  input  logic [15:0]      s_axis_b_tdata,
  output logic             m_axis_result_tvalid,
  input  logic             m_axis_result_tready,
  output logic [15:0]      m_axis_result_tdata,
  output logic [TAG_W-1:0] m_axis_result_tuser
);

  logic adv, accept;

  // Operand capture stage
  logic             v0_q;
  logic [15:0]      a0_q, b0_q;
  logic [TAG_W-1:0] tag0_q;

  // S1: unpacked operands
  logic             v1_q, sign1_q, nan1_q, inf1_q, zero1_q;
  logic signed [6:0] exp1_q;
  logic [21:0]      prod1_q;
  logic [TAG_W-1:0] tag1_q;
  logic             sign1_d, nan1_d, inf1_d, zero1_d;
  logic signed [6:0] exp1_d;
  logic [21:0]      prod1_d;

  // S2: normalised and rounded
  logic             v2_q, sign2_q, nan2_q, inf2_q, zero2_q;
  logic signed [6:0] exp2_q;
  logic [9:0]       frac2_q;
  logic [TAG_W-1:0] tag2_q;
  logic signed [6:0] exp2_d;
  logic [9:0]       frac2_d;

  // S3: output register
  logic             v3_q;
  logic [15:0]      data3_q, data3_d;
  logic [TAG_W-1:0] tag3_q;

  assign adv    = !v3_q || m_axis_result_tready;
  assign accept = s_axis_a_tvalid && s_axis_b_tvalid && adv;

  // Readies are forced low during reset even though the empty pipeline would allow advance
  assign s_axis_a_tready = aresetn && adv && s_axis_b_tvalid;
  assign s_axis_b_tready = aresetn && adv && s_axis_a_tvalid;

  assign m_axis_result_tvalid = v3_q;
  assign m_axis_result_tdata  = data3_q;
  assign m_axis_result_tuser  = tag3_q;

  always_comb begin
    logic [4:0] ea, eb;
    logic [9:0] ma, mb;
    logic       a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    ea      = a0_q[14:10];
    eb      = b0_q[14:10];
    ma      = a0_q[9:0];
    mb      = b0_q[9:0];
    a_zero  = (ea == '0);
    b_zero  = (eb == '0);
    a_inf   = (ea == '1) && (ma == '0);
    b_inf   = (eb == '1) && (mb == '0);
    a_nan   = (ea == '1) && (ma != '0);
    b_nan   = (eb == '1) && (mb != '0);
    sign1_d = a0_q[15] ^ b0_q[15];
    nan1_d  = a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero);
    inf1_d  = a_inf || b_inf;
    zero1_d = a_zero || b_zero;
    exp1_d  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 7'sd15;
    prod1_d = 22'({1'b1, ma}) * 22'({1'b1, mb});
  end

  always_comb begin
    logic [10:0]       mant;
    logic [11:0]       mant_r;
    logic              guard, sticky, round_up;
    logic signed [6:0] exp_n;
    if (prod1_q[21]) begin
      mant   = prod1_q[21:11];
      guard  = prod1_q[10];
      sticky = |prod1_q[9:0];
      exp_n  = exp1_q + 7'sd1;
    end else begin
      mant   = prod1_q[20:10];
      guard  = prod1_q[9];
      sticky = |prod1_q[8:0];
      exp_n  = exp1_q;
    end
    round_up = guard && (sticky || mant[0]);
    mant_r   = {1'b0, mant} + 12'(round_up);
    if (mant_r[11]) begin
      frac2_d = mant_r[10:1];
      exp2_d  = exp_n + 7'sd1;
    end else begin
      frac2_d = mant_r[9:0];
      exp2_d  = exp_n;
    end
  end

  always_comb begin
    data3_d = {sign2_q, exp2_q[4:0], frac2_q};
    if (nan2_q) begin
      data3_d = 16'h7E00;
    end else if (inf2_q) begin
      data3_d = {sign2_q, 5'h1F, 10'h000};
    end else if (zero2_q) begin
      data3_d = {sign2_q, 15'h0000};
    end else if (exp2_q > 7'sd30) begin
      data3_d = {sign2_q, 5'h1F, 10'h000};
    end else if (exp2_q < 7'sd1) begin
      data3_d = {sign2_q, 15'h0000};
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      v0_q    <= 1'b0;
      a0_q    <= '0;
      b0_q    <= '0;
      tag0_q  <= '0;
      v1_q    <= 1'b0;
      sign1_q <= 1'b0;
      nan1_q  <= 1'b0;
      inf1_q  <= 1'b0;
      zero1_q <= 1'b0;
      exp1_q  <= '0;
      prod1_q <= '0;
      tag1_q  <= '0;
      v2_q    <= 1'b0;
      sign2_q <= 1'b0;
      nan2_q  <= 1'b0;
      inf2_q  <= 1'b0;
      zero2_q <= 1'b0;
      exp2_q  <= '0;
      frac2_q <= '0;
      tag2_q  <= '0;
      v3_q    <= 1'b0;
      data3_q <= '0;
      tag3_q  <= '0;
    end else if (adv) begin
      v0_q    <= accept;
      a0_q    <= s_axis_a_tdata;
      b0_q    <= s_axis_b_tdata;
      tag0_q  <= s_axis_a_tuser;
      v1_q    <= v0_q;
      sign1_q <= sign1_d;
      nan1_q  <= nan1_d;
      inf1_q  <= inf1_d;
      zero1_q <= zero1_d;
      exp1_q  <= exp1_d;
      prod1_q <= prod1_d;
      tag1_q  <= tag0_q;
      v2_q    <= v1_q;
      sign2_q <= sign1_q;
      nan2_q  <= nan1_q;
      inf2_q  <= inf1_q;
      zero2_q <= zero1_q;
      exp2_q  <= exp2_d;
      frac2_q <= frac2_d;
      tag2_q  <= tag1_q;
      v3_q    <= v2_q;
      data3_q <= data3_d;
      tag3_q  <= tag2_q;
    end
  end

endmodule

// File: tb/tb_fp16_mul_axis.sv
// Self-checking bench for fp16_mul_axis: integer-arithmetic binary16 product model,
// scoreboard compare at every negedge, and directed latency/stall/join/reset scenarios.
module tb_fp16_mul_axis;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        a_valid, a_ready, b_valid, b_ready;
  logic [15:0] a_data, b_data;
  logic [3:0]  a_user;
  logic        r_valid, r_ready;
  logic [15:0] r_data;
  logic [3:0]  r_user;

  int tests = 0;
  int fails = 0;
  int accepts = 0;
  int results = 0;

  typedef struct {
    logic [15:0] d;
    logic [3:0]  t;
  } exp_t;
  exp_t sb[$];

  always #5 aclk = ~aclk;

  fp16_mul_axis #(.TAG_W(4)) dut (
    .aclk                 (aclk),
    .aresetn              (aresetn),
    .s_axis_a_tvalid      (a_valid),
    .s_axis_a_tready      (a_ready),
    .s_axis_a_tdata       (a_data),
    .s_axis_a_tuser       (a_user),
    .s_axis_b_tvalid      (b_valid),
    .s_axis_b_tready      (b_ready),
    .s_axis_b_tdata       (b_data),
    .m_axis_result_tvalid (r_valid),
    .m_axis_result_tready (r_ready),
    .m_axis_result_tdata  (r_data),
    .m_axis_result_tuser  (r_user)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Exact significand product, rounded by remainder comparison against half an ulp.
  function automatic logic [15:0] model(input logic [15:0] a, input logic [15:0] b);
    int     ea = int'(a[14:10]);
    int     eb = int'(b[14:10]);
    int     ma = int'(a[9:0]);
    int     mb = int'(b[9:0]);
    logic   s  = a[15] ^ b[15];
    bit     az = (ea == 0);
    bit     bz = (eb == 0);
    bit     ai = (ea == 31) && (ma == 0);
    bit     bi = (eb == 31) && (mb == 0);
    bit     an = (ea == 31) && (ma != 0);
    bit     bn = (eb == 31) && (mb != 0);
    longint p, q, r, half;
    int     msb, sh, e;
    if (an || bn || (ai && bz) || (bi && az)) return 16'h7E00;
    if (ai || bi) return {s, 15'h7C00};
    if (az || bz) return {s, 15'h0000};
    p = longint'(ma + 1024) * longint'(mb + 1024);
    msb = 0;
    for (int i = 0; i < 24; i++) if (p[i]) msb = i;
    sh   = msb - 10;
    q    = p >> sh;
    r    = p - (q << sh);
    half = longint'(1) << (sh - 1);
    if (r > half || (r == half && q[0])) q++;
    e = ea + eb + msb - 35;
    if (q == 2048) begin
      q = 1024;
      e++;
    end
    if (e > 30) return {s, 15'h7C00};
    if (e < 1) return {s, 15'h0000};
    return {s, 5'(e), 10'(q - 1024)};
  endfunction

  // Compare process: handshake rules, stall stability, scoreboard on every output transfer.
  logic        prev_stall = 1'b0;
  logic [15:0] prev_data;
  logic [3:0]  prev_user;
  always @(negedge aclk) begin
    exp_t e;
    if (!aresetn) begin
      prev_stall = 1'b0;
      check("reset_a_tready", a_ready, 0);
      check("reset_b_tready", b_ready, 0);
      check("reset_tvalid", r_valid, 0);
    end else begin
      check("a_tready_rule", a_ready, (!r_valid || r_ready) && b_valid);
      check("b_tready_rule", b_ready, (!r_valid || r_ready) && a_valid);
      if (prev_stall) begin
        check("stall_hold_valid", r_valid, 1);
        check("stall_hold_data", r_data, prev_data);
        check("stall_hold_user", r_user, prev_user);
      end
      if (a_valid && b_valid && a_ready) begin
        e.d = model(a_data, b_data);
        e.t = a_user;
        sb.push_back(e);
        accepts++;
      end
      if (r_valid && r_ready) begin
        if (sb.size() == 0) begin
          fail_now("unexpected_result");
        end else begin
          e = sb.pop_front();
          check("result_data_vs_model", r_data, e.d);
          check("result_tag_vs_model", r_user, e.t);
        end
        results++;
      end
      prev_stall = r_valid && !r_ready;
      prev_data  = r_data;
      prev_user  = r_user;
    end
  end

  task automatic drive_pair(input logic [15:0] a, input logic [15:0] b,
                            input logic [3:0] tag, output bit ok);
    int n = 0;
    bit hs = 1'b0;
    a_valid = 1'b1;
    b_valid = 1'b1;
    a_data  = a;
    b_data  = b;
    a_user  = tag;
    while (!hs && n < 100) begin
      @(negedge aclk);
      hs = a_ready;
      @(posedge aclk);
      #1;
      n++;
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    ok = hs;
    if (!hs) fail_now("accept_timeout");
  endtask

  task automatic single(input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] tag, input logic [15:0] req);
    int lat = 0;
    bit ok;
    drive_pair(a, b, tag, ok);
    if (!ok) return;
    while (!r_valid && lat < 20) begin
      @(posedge aclk);
      #1;
      lat++;
    end
    check("latency", lat, 3);
    check("result_data", r_data, req);
    check("result_tag", r_user, tag);
    @(posedge aclk);
    #1;
    check("valid_one_cycle", r_valid, 0);
  endtask

  logic [15:0] va [11] = '{16'h4000, 16'h3C00, 16'h3C01, 16'h3C01, 16'h7C00, 16'h7C00,
                           16'h7BFF, 16'h8400, 16'h0001, 16'h7E01, 16'h8000};
  logic [15:0] vb [11] = '{16'h4000, 16'hC000, 16'h3C01, 16'h3E00, 16'h0000, 16'hC000,
                           16'h4000, 16'h3800, 16'h7BFF, 16'h3C00, 16'hFC00};
  logic [15:0] vr [11] = '{16'h4400, 16'hC000, 16'h3C02, 16'h3E02, 16'h7E00, 16'hFC00,
                           16'h7C00, 16'h8000, 16'h0000, 16'h7E00, 16'h7E00};
  logic [15:0] bpa [6] = '{16'h4000, 16'h3C01, 16'hC200, 16'h3555, 16'h7BFF, 16'h0400};
  logic [15:0] bpb [6] = '{16'h4000, 16'h3C01, 16'h4100, 16'h3555, 16'h3C00, 16'h3C00};

  initial begin
    #200000;
    $display("FAIL watchdog_timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int res0, acc0, n;
    bit ok;
    aresetn = 1'b0;
    a_valid = 1'b1;
    b_valid = 1'b1;
    a_data  = '0;
    b_data  = '0;
    a_user  = '0;
    r_ready = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    check("rst_tvalid", r_valid, 0);
    check("rst_tdata", r_data, 0);
    check("rst_tuser", r_user, 0);
    check("rst_a_tready", a_ready, 0);
    check("rst_b_tready", b_ready, 0);
    a_valid = 1'b0;
    b_valid = 1'b0;
    #2 aresetn = 1'b1;
    @(posedge aclk);
    #1;

    check("model_4000x4000", model(16'h4000, 16'h4000), 16'h4400);
    check("model_tie_even", model(16'h3C01, 16'h3E00), 16'h3E02);
    check("model_overflow", model(16'h7BFF, 16'h4000), 16'h7C00);
    check("model_inf_x_zero", model(16'h7C00, 16'h0000), 16'h7E00);
    check("model_underflow", model(16'h8400, 16'h3800), 16'h8000);

    for (int i = 0; i < 11; i++) single(va[i], vb[i], 4'((i + 3) % 16), vr[i]);

    // Join: A alone must not be consumed
    acc0    = accepts;
    a_valid = 1'b1;
    a_data  = 16'h3C00;
    a_user  = 4'h9;
    b_valid = 1'b0;
    repeat (4) begin
      @(posedge aclk);
      #1;
      check("join_lone_a_ready", a_ready, 0);
    end
    check("join_no_accept", accepts - acc0, 0);
    check("join_no_result", r_valid, 0);
    single(16'h3C00, 16'h4400, 4'h9, 16'h4400);

    // Backpressure: six pairs back-to-back, stall right after the first result
    res0 = results;
    fork
      begin
        bit okb;
        for (int i = 0; i < 6; i++) drive_pair(bpa[i], bpb[i], 4'(i), okb);
      end
      begin
        int w = 0;
        while (!r_valid && w < 50) begin
          @(posedge aclk);
          #1;
          w++;
        end
        if (!r_valid) fail_now("bp_first_result_timeout");
        @(posedge aclk);
        #1;
        r_ready = 1'b0;
        @(negedge aclk);
        check("bp_stall_a_tready", a_ready, 0);
        check("bp_stall_b_tready", b_ready, 0);
        repeat (5) @(posedge aclk);
        #1;
        r_ready = 1'b1;
      end
    join
    n = 0;
    while ((sb.size() != 0 || r_valid) && n < 100) begin
      @(posedge aclk);
      #1;
      n++;
    end
    check("bp_result_count", results - res0, 6);
    check("bp_drained", sb.size(), 0);

    // Reset mid-flight
    for (int i = 0; i < 3; i++) drive_pair(16'h4000, 16'h3C00, 4'(i + 1), ok);
    @(posedge aclk);
    #1;
    check("pre_reset_valid", r_valid, 1);
    a_valid = 1'b1;
    b_valid = 1'b1;
    #2 aresetn = 1'b0;
    sb.delete();
    #1;
    check("async_reset_tvalid", r_valid, 0);
    check("async_reset_a_tready", a_ready, 0);
    check("async_reset_b_tready", b_ready, 0);
    repeat (2) @(posedge aclk);
    #1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    #2 aresetn = 1'b1;
    repeat (6) begin
      @(posedge aclk);
      #1;
      check("post_reset_idle", r_valid, 0);
    end
    single(16'h4200, 16'h4000, 4'h7, 16'h4600);
    check("final_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
